// File: rtl/mem_stage_unit.sv
// Memory stage of the 5-stage MIPS pipeline: ALU results pass straight through,
// loads and stores run as request/response transactions on the data bus.
module mem_stage_unit #(
   parameter int DST_W            = 5,
   parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_opcode,
   input  logic [31:0]      in_vale,
   input  logic [31:0]      in_vala,
   input  logic [DST_W-1:0] in_dst,
   input  logic [31:0]      in_pc,
   output logic             dreq_valid,
   output logic [31:0]      dreq_addr,
   output logic [3:0]       dreq_strobe,
   output logic [31:0]      dreq_data,
   input  logic             dresp_addr_ok,
   input  logic             dresp_data_ok,
   input  logic [31:0]      dresp_data,
   output logic             out_valid,
   output logic [DST_W-1:0] out_dst,
   output logic [31:0]      out_data,
   output logic [31:0]      out_pc,
   output logic             out_exc,
   output logic [31:0]      out_badaddr
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      vala_q, vala_d;
   logic [31:0]      pc_q, pc_d;
   logic [DST_W-1:0] dst_q, dst_d;
   logic             out_valid_q, out_valid_d;
   logic             out_exc_q, out_exc_d;
   logic [DST_W-1:0] out_dst_q, out_dst_d;
   logic [31:0]      out_data_q, out_data_d;
   logic [31:0]      out_pc_q, out_pc_d;
   logic [31:0]      out_badaddr_q, out_badaddr_d;

   logic        in_is_mem, in_is_half, in_is_word, in_misaligned;
   logic        is_store, done_now;
   logic [1:0]  off;
   logic [3:0]  strobe;
   logic [31:0] wdata, shifted, load_val;

   always_comb begin
      in_is_mem  = 1'b0;
      in_is_half = 1'b0;
      in_is_word = 1'b0;
      case (in_opcode)
         OP_LB, OP_LBU, OP_SB: in_is_mem = 1'b1;
         OP_LH, OP_LHU, OP_SH: begin
            in_is_mem  = 1'b1;
            in_is_half = 1'b1;
         end
         OP_LW, OP_SW: begin
            in_is_mem  = 1'b1;
            in_is_word = 1'b1;
         end
         default: ;
      endcase
      in_misaligned = ADDR_ALIGN_CHECK &&
                      ((in_is_half && in_vale[0]) || (in_is_word && (in_vale[1:0] != 2'b00)));
   end

   // Store lane encoding and load extraction both key off the captured byte offset.
   always_comb begin
      off      = addr_q[1:0];
      is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
      strobe   = 4'h0;
      wdata    = 32'h0;
      case (op_q)
         OP_SB: begin
            strobe = 4'b0001 << off;
            wdata  = {4{vala_q[7:0]}};
         end
         OP_SH: begin
            strobe = 4'b0011 << off;
            wdata  = {2{vala_q[15:0]}};
         end
         OP_SW: begin
            strobe = 4'hF;
            wdata  = vala_q;
         end
         default: ;
      endcase
      shifted = dresp_data >> {off, 3'b000};
      case (op_q)
         OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
         OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
         OP_LBU:  load_val = {24'h0, shifted[7:0]};
         OP_LHU:  load_val = {16'h0, shifted[15:0]};
         OP_LW:   load_val = dresp_data;
         default: load_val = 32'h0;
      endcase
   end

   assign in_ready    = (state_q == S_IDLE);
   assign dreq_valid  = (state_q == S_REQ);
   assign dreq_addr   = dreq_valid ? {addr_q[31:2], 2'b00} : 32'h0;
   assign dreq_strobe = dreq_valid ? strobe : 4'h0;
   assign dreq_data   = dreq_valid ? wdata : 32'h0;

   assign out_valid   = out_valid_q;
   assign out_dst     = out_dst_q;
   assign out_data    = out_data_q;
   assign out_pc      = out_pc_q;
   assign out_exc     = out_exc_q;
   assign out_badaddr = out_badaddr_q;

   assign done_now = ((state_q == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                     ((state_q == S_WAIT) && dresp_data_ok);

   // Result registers default to zero so every output is a clean one-cycle pulse.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      vala_d        = vala_q;
      pc_d          = pc_q;
      dst_d         = dst_q;
      out_valid_d   = 1'b0;
      out_exc_d     = 1'b0;
      out_dst_d     = '0;
      out_data_d    = 32'h0;
      out_pc_d      = 32'h0;
      out_badaddr_d = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_misaligned) begin
                  out_valid_d   = 1'b1;
                  out_exc_d     = 1'b1;
                  out_badaddr_d = in_vale;
                  out_pc_d      = in_pc;
               end else if (in_is_mem) begin
                  op_d    = in_opcode;
                  addr_d  = in_vale;
                  vala_d  = in_vala;
                  pc_d    = in_pc;
                  dst_d   = in_dst;
                  state_d = S_REQ;
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = in_vale;
                  out_dst_d   = in_dst;
                  out_pc_d    = in_pc;
               end
            end
         end
         S_REQ: begin
            if (dresp_addr_ok) begin
               state_d = dresp_data_ok ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (dresp_data_ok) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (done_now) begin
         out_valid_d = 1'b1;
         out_pc_d    = pc_q;
         out_data_d  = is_store ? 32'h0 : load_val;
         out_dst_d   = is_store ? '0 : dst_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         op_q          <= 6'h0;
         addr_q        <= 32'h0;
         vala_q        <= 32'h0;
         pc_q          <= 32'h0;
         dst_q         <= '0;
         out_valid_q   <= 1'b0;
         out_exc_q     <= 1'b0;
         out_dst_q     <= '0;
         out_data_q    <= 32'h0;
         out_pc_q      <= 32'h0;
         out_badaddr_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         vala_q        <= vala_d;
         pc_q          <= pc_d;
         dst_q         <= dst_d;
         out_valid_q   <= out_valid_d;
         out_exc_q     <= out_exc_d;
         out_dst_q     <= out_dst_d;
         out_data_q    <= out_data_d;
         out_pc_q      <= out_pc_d;
         out_badaddr_q <= out_badaddr_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: table of single-cycle ops plus
// hand-written dbus handshake sequences for loads, stores and reset.
module tb_mem_stage_unit;

   localparam int DST_W = 5;

   logic             clk = 1'b0;
   logic             resetn;
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_opcode;
   logic [31:0]      in_vale;
   logic [31:0]      in_vala;
   logic [DST_W-1:0] in_dst;
   logic [31:0]      in_pc;
   logic             dreq_valid;
   logic [31:0]      dreq_addr;
   logic [3:0]       dreq_strobe;
   logic [31:0]      dreq_data;
   logic             dresp_addr_ok;
   logic             dresp_data_ok;
   logic [31:0]      dresp_data;
   logic             out_valid;
   logic [DST_W-1:0] out_dst;
   logic [31:0]      out_data;
   logic [31:0]      out_pc;
   logic             out_exc;
   logic [31:0]      out_badaddr;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [5:0]  opcode;
      logic [31:0] vale;
      logic [31:0] vala;
      logic [4:0]  dst;
      logic [31:0] pc;
      logic        exp_exc;
      logic [4:0]  exp_dst;
      logic [31:0] exp_data;
      logic [31:0] exp_badaddr;
      logic        chk_data;
   } vec_t;

   vec_t vecs[8];

   mem_stage_unit #(.DST_W(DST_W), .ADDR_ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_vale(in_vale), .in_vala(in_vala), .in_dst(in_dst), .in_pc(in_pc),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
      .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
      .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .out_valid(out_valid), .out_dst(out_dst), .out_data(out_data),
      .out_pc(out_pc), .out_exc(out_exc), .out_badaddr(out_badaddr)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [5:0] op, input logic [31:0] vale,
                                 input logic [31:0] vala, input logic [4:0] dst, input logic [31:0] pc);
      in_valid  = v;
      in_opcode = op;
      in_vale   = vale;
      in_vala   = vala;
      in_dst    = dst;
      in_pc     = pc;
   endtask

   task automatic set_resp(input logic aok, input logic dok, input logic [31:0] data);
      dresp_addr_ok = aok;
      dresp_data_ok = dok;
      dresp_data    = data;
   endtask

   initial begin
      vecs[0] = '{6'h00, 32'h0000_1234, 32'h0, 5'd3,  32'h100, 1'b0, 5'd3,  32'h0000_1234, 32'h0, 1'b1};
      vecs[1] = '{6'h09, 32'hDEAD_BEEF, 32'h0, 5'd31, 32'h104, 1'b0, 5'd31, 32'hDEAD_BEEF, 32'h0, 1'b1};
      vecs[2] = '{6'h23, 32'h0000_3001, 32'h0, 5'd7,  32'h108, 1'b1, 5'd0,  32'h0, 32'h0000_3001, 1'b0};
      vecs[3] = '{6'h21, 32'h0000_3003, 32'h0, 5'd8,  32'h10C, 1'b1, 5'd0,  32'h0, 32'h0000_3003, 1'b0};
      vecs[4] = '{6'h2B, 32'h0000_3002, 32'h55, 5'd0, 32'h110, 1'b1, 5'd0,  32'h0, 32'h0000_3002, 1'b0};
      vecs[5] = '{6'h29, 32'h0000_3005, 32'h66, 5'd0, 32'h114, 1'b1, 5'd0,  32'h0, 32'h0000_3005, 1'b0};
      vecs[6] = '{6'h0F, 32'h0000_0000, 32'h0, 5'd0,  32'h118, 1'b0, 5'd0,  32'h0, 32'h0, 1'b1};
      vecs[7] = '{6'h25, 32'h0000_4001, 32'h0, 5'd12, 32'h11C, 1'b1, 5'd0,  32'h0, 32'h0000_4001, 1'b0};

      resetn = 1'b0;
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      set_resp(1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      check_output("rst_in_ready", 32'(in_ready), 32'h1);
      check_output("rst_out_valid", 32'(out_valid), 32'h0);
      check_output("rst_dreq_valid", 32'(dreq_valid), 32'h0);
      check_output("rst_out_data", out_data, 32'h0);
      check_output("rst_out_exc", 32'(out_exc), 32'h0);
      resetn = 1'b1;
      @(negedge clk);

      // single-cycle ops: ALU pass-through and misaligned exceptions
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, vecs[i].opcode, vecs[i].vale, vecs[i].vala, vecs[i].dst, vecs[i].pc);
         @(negedge clk);
         check_output($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'h1);
         check_output($sformatf("v%0d_out_exc", i), 32'(out_exc), 32'(vecs[i].exp_exc));
         check_output($sformatf("v%0d_out_dst", i), 32'(out_dst), 32'(vecs[i].exp_dst));
         check_output($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
         check_output($sformatf("v%0d_dreq_valid", i), 32'(dreq_valid), 32'h0);
         check_output($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
         if (vecs[i].chk_data) check_output($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
         if (vecs[i].exp_exc) check_output($sformatf("v%0d_badaddr", i), out_badaddr, vecs[i].exp_badaddr);
      end
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      @(negedge clk);
      check_output("idle_out_valid", 32'(out_valid), 32'h0);

      // LB zero-wait, sign-extended top byte
      apply_stimulus(1'b1, 6'h20, 32'h0000_1003, 32'h0, 5'd4, 32'h200);
      @(negedge clk);
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      check_output("lb_dreq_valid", 32'(dreq_valid), 32'h1);
      check_output("lb_dreq_addr", dreq_addr, 32'h0000_1000);
      check_output("lb_dreq_strobe", 32'(dreq_strobe), 32'h0);
      check_output("lb_in_ready", 32'(in_ready), 32'h0);
      check_output("lb_early_valid", 32'(out_valid), 32'h0);
      set_resp(1'b1, 1'b1, 32'h80FF_0000);
      @(negedge clk);
      set_resp(1'b0, 1'b0, 32'h0);
      check_output("lb_out_valid", 32'(out_valid), 32'h1);
      check_output("lb_out_data", out_data, 32'hFFFF_FF80);
      check_output("lb_out_dst", 32'(out_dst), 32'd4);
      check_output("lb_out_pc", out_pc, 32'h200);
      check_output("lb_out_exc", 32'(out_exc), 32'h0);
      check_output("lb_done_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      check_output("lb_pulse_end", 32'(out_valid), 32'h0);
      check_output("lb_ready_back", 32'(in_ready), 32'h1);

      // SH with delayed addr_ok and data_ok
      apply_stimulus(1'b1, 6'h29, 32'h0000_2002, 32'hABCD_1234, 5'd9, 32'h300);
      @(negedge clk);
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) set_resp(1'b1, 1'b0, 32'h0);
         check_output($sformatf("sh_req%0d_valid", k), 32'(dreq_valid), 32'h1);
         check_output($sformatf("sh_req%0d_addr", k), dreq_addr, 32'h0000_2000);
         check_output($sformatf("sh_req%0d_strobe", k), 32'(dreq_strobe), 32'hC);
         check_output($sformatf("sh_req%0d_data", k), dreq_data, 32'h1234_1234);
         check_output($sformatf("sh_req%0d_ready", k), 32'(in_ready), 32'h0);
         @(negedge clk);
      end
      set_resp(1'b0, 1'b0, 32'h0);
      check_output("sh_wait_dreq", 32'(dreq_valid), 32'h0);
      check_output("sh_wait_ready", 32'(in_ready), 32'h0);
      check_output("sh_wait_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      set_resp(1'b0, 1'b1, 32'hFFFF_FFFF);
      check_output("sh_wait2_dreq", 32'(dreq_valid), 32'h0);
      check_output("sh_wait2_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      set_resp(1'b0, 1'b0, 32'h0);
      check_output("sh_out_valid", 32'(out_valid), 32'h1);
      check_output("sh_out_dst", 32'(out_dst), 32'h0);
      check_output("sh_out_exc", 32'(out_exc), 32'h0);
      check_output("sh_out_pc", out_pc, 32'h300);
      check_output("sh_done_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      check_output("sh_pulse_end", 32'(out_valid), 32'h0);

      // SB zero-wait: lane-replicated byte, strobe on lane 1
      apply_stimulus(1'b1, 6'h28, 32'h0000_6001, 32'h1234_56A5, 5'd5, 32'h380);
      @(negedge clk);
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      check_output("sb_dreq_strobe", 32'(dreq_strobe), 32'h2);
      check_output("sb_dreq_data", dreq_data, 32'hA5A5_A5A5);
      check_output("sb_dreq_addr", dreq_addr, 32'h0000_6000);
      set_resp(1'b1, 1'b1, 32'h0);
      @(negedge clk);
      set_resp(1'b0, 1'b0, 32'h0);
      check_output("sb_out_valid", 32'(out_valid), 32'h1);
      check_output("sb_out_dst", 32'(out_dst), 32'h0);
      @(negedge clk);

      // LHU upper half, then an ALU op right after DONE
      apply_stimulus(1'b1, 6'h25, 32'h0000_4002, 32'h0, 5'd10, 32'h400);
      @(negedge clk);
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      set_resp(1'b1, 1'b1, 32'h9876_5432);
      @(negedge clk);
      set_resp(1'b0, 1'b0, 32'h0);
      check_output("lhu_out_valid", 32'(out_valid), 32'h1);
      check_output("lhu_out_data", out_data, 32'h0000_9876);
      check_output("lhu_out_dst", 32'(out_dst), 32'd10);
      @(negedge clk);
      check_output("b2b_ready", 32'(in_ready), 32'h1);
      apply_stimulus(1'b1, 6'h00, 32'h0000_0077, 32'h0, 5'd2, 32'h404);
      @(negedge clk);
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      check_output("b2b_out_valid", 32'(out_valid), 32'h1);
      check_output("b2b_out_data", out_data, 32'h0000_0077);
      check_output("b2b_out_dst", 32'(out_dst), 32'd2);
      check_output("b2b_out_pc", out_pc, 32'h404);
      @(negedge clk);

      // reset while waiting for data, with stray data_ok around it
      apply_stimulus(1'b1, 6'h23, 32'h0000_5000, 32'h0, 5'd11, 32'h500);
      @(negedge clk);
      apply_stimulus(1'b0, 6'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      set_resp(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check_output("rw_wait_dreq", 32'(dreq_valid), 32'h0);
      check_output("rw_wait_ready", 32'(in_ready), 32'h0);
      resetn = 1'b0;
      set_resp(1'b0, 1'b1, 32'h1234_5678);
      @(negedge clk);
      check_output("rw_rst_ready", 32'(in_ready), 32'h1);
      check_output("rw_rst_valid", 32'(out_valid), 32'h0);
      check_output("rw_rst_data", out_data, 32'h0);
      check_output("rw_rst_dreq", 32'(dreq_valid), 32'h0);
      check_output("rw_rst_addr", dreq_addr, 32'h0);
      resetn = 1'b1;
      @(negedge clk);
      check_output("rw_stray_valid", 32'(out_valid), 32'h0);
      check_output("rw_stray_ready", 32'(in_ready), 32'h1);
      check_output("rw_stray_dreq", 32'(dreq_valid), 32'h0);
      set_resp(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check_output("rw_final_valid", 32'(out_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Memory stage of the 5-stage MIPS pipeline; the consumer end of the execute→memory pipeline interface.
- Accepts one execute-stage result at a time: opcode, ALU result (valE), store data (valA) and destination register (dstE/dstM).
- Loads and stores run as multi-cycle transactions on the data bus (dbus) under an FSM. All other ops pass through with one cycle of latency.
- Produces a registered result for writeback, plus a ready signal that stalls execute.

Parameters:
- DST_W, 5, destination register index width.
- ADDR_ALIGN_CHECK, 1, when 1, misaligned accesses raise out_exc and issue no bus request.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  unit can accept this cycle; high only in IDLE.
- in_opcode  in  6  MIPS primary opcode.
- in_vale  in  32  ALU result: effective address for memory ops, write value otherwise.
- in_vala  in  32  store data (rt).
- in_dst  in  DST_W  destination register; 0 means no write.
- in_pc  in  32  instruction PC, carried to output.
- dreq_valid  out  1  dbus request valid.
- dreq_addr  out  32  dbus address, word aligned ({addr[31:2],2'b00}).
- dreq_strobe  out  4  byte write enables; 0 for loads.
- dreq_data  out  32  lane-replicated store data.
- dresp_addr_ok  in  1  request accepted.
- dresp_data_ok  in  1  response/data valid.
- dresp_data  in  32  raw load word.
- out_valid  out  1  one-cycle pulse: result to writeback.
- out_dst  out  DST_W  writeback register; 0 for stores and exceptions.
- out_data  out  32  writeback value.
- out_pc  out  32  PC of the completed instruction.
- out_exc  out  1  address-error exception flag.
- out_badaddr  out  32  faulting address when out_exc=1.

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE.
  - All outputs are 0, except in_ready=1.
  - Reset mid-transaction aborts it: dreq_valid=0 from the next cycle.
  - A dresp_data_ok arriving in IDLE is ignored.
- Accept: in_valid && in_ready at edge N.
- Non-memory opcode:
  - At N+1: out_valid=1, out_data=in_vale, out_dst=in_dst, out_pc=in_pc.
  - State stays IDLE.
- Memory opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- Misaligned check (when ADDR_ALIGN_CHECK=1):
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Result: no bus request. At N+1: out_valid=1, out_exc=1, out_badaddr=addr, out_dst=0.
- Aligned memory op: captured at N; state→REQ at N+1.
- FSM states:
  - IDLE: in_ready=1, dreq_valid=0.
  - REQ: dreq_valid=1 and all dreq_* held stable until dresp_addr_ok.
    - addr_ok && data_ok in the same cycle → DONE.
    - addr_ok alone → WAIT.
  - WAIT: dreq_valid=0. On dresp_data_ok → DONE, latching dresp_data.
  - DONE: out_valid=1 for exactly one cycle, then IDLE. in_ready=0 in DONE; it returns to 1 the cycle after.
- Latency:
  - Zero-wait memory (addr_ok and data_ok both in the first REQ cycle): out_valid at N+2.
  - Otherwise: out_valid the cycle after data_ok is sampled.
- Store encoding, with o=addr[1:0]:
  - SB: strobe=4'b0001<<o, data={4{vala[7:0]}}.
  - SH: strobe=4'b0011<<o, data={2{vala[15:0]}}.
  - SW: strobe=4'hF, data=vala.
  - Stores complete with out_dst=0.
- Load extraction from the latched word w:
  - byte = w>>(8*o); half = w>>(8*o).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW=w.
  - Load result goes to out_data with out_dst=in_dst.
- out_exc is 0 on every non-exception completion.

Test Plan:
- Reset then ADDU-style op (opcode 0x00, vale=0x1234, dst=3) → out_valid one cycle later, out_data=0x1234, out_dst=3, no dreq_valid.
- LB addr=0x1003, memory word 0x80FF_0000, addr_ok+data_ok same cycle → dreq_addr=0x1000, strobe=0, out_data=0xFFFF_FF80, out_valid at N+2.
- SH addr=0x2002, vala=0xABCD_1234, addr_ok delayed 3 cycles, data_ok 2 cycles later → dreq stable 3 cycles, strobe=4'b1100, data=0x1234_1234, out_dst=0, in_ready=0 throughout.
- LW addr=0x3001 → no dreq_valid, out_exc=1, out_badaddr=0x3001, out_dst=0 next cycle.
- LHU addr=0x4002 word 0x9876_5432 → out_data=0x0000_9876; back-to-back ops accepted the cycle after DONE.
- resetn low while in WAIT → IDLE next cycle, outputs 0, stray data_ok ignored, no out_valid.
